ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, for
//  example 0xED (set LEDs) or 0xFF (reset). It sits beside the PS/2 scan-code
//  receiver on the same two open-drain lines. The CPU-facing side is a single-byte
//  write port with busy/done/err status.
// PARAMETERS
//  INHIBIT_CYCLES  5000     clk cycles the clock line is held low before the start bit (>=100us).
//  TIMEOUT_CYCLES  1000000  clk cycles allowed from clock release to the ack bit.
//  FILTER_CYCLES   19       cycles an input must be stable before its filtered value updates.
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-high
//  ps2_clk      in   1  raw PS/2 clock line (async)
//  ps2_data     in   1  raw PS/2 data line (async)
//  ps2_clk_oe   out  1  1 = pull PS/2 clock low; 0 = release
//  ps2_data_oe  out  1  1 = pull PS/2 data low; 0 = release
//  wen          in   1  write strobe; accepted only when busy=0
//  wdata        in   8  command byte
//  busy         out  1  transfer in progress
//  done         out  1  1-cycle pulse: byte sent and acknowledged
//  err          out  1  1-cycle pulse: timeout (or NACK, see CONFIGURATION)
// BEHAVIOUR
//  - Reset: ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, err=0, state=IDLE.
//    Reset mid-frame releases both lines on the next clk edge.
//  - Inputs: each line goes through a 2-flop synchronizer, then a stability filter
//    (FILTER_CYCLES). fall = filtered clock was 1 on the previous cycle and is 0 now.
//  - Parity: P = ~^wdata (odd parity). wdata is latched in the cycle wen is accepted.
//  - wen while busy=1 is ignored; the byte in flight is unaffected.
//  - FSM:
//    IDLE: on wen -> INHIBIT, busy=1 from the next cycle.
//    INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES, then -> REQ.
//    REQ: ps2_data_oe=1 (start bit 0) for 1 cycle while the clock is still held, then
//      ps2_clk_oe=0 -> SHIFT. The timeout counter starts here.
//    SHIFT: on each fall, present the next bit (ps2_data_oe = ~bit), counted by a
//      4-bit edge counter:
//      falls 1..8 = wdata[0..7], LSB first; fall 9 = P; fall 10 = stop bit
//      (ps2_data_oe=0); fall 11 -> ACK.
//    ACK: the filtered ps2_data is sampled in the cycle fall 11 is detected; 0 = ACK.
//      -> WAITIDLE.
//    WAITIDLE: wait until both filtered lines are 1, then -> IDLE. In that cycle,
//      done=1 (or err=1 on NACK) and busy=0.
//  - Timeout: if fall 11 has not occurred within TIMEOUT_CYCLES of leaving REQ:
//      release both lines, pulse err=1, busy=0, -> IDLE.
//  - done and err are never asserted in the same cycle.
//  - Latency from accept to done: INHIBIT_CYCLES + 1 + device clocking (~11 PS/2 clocks).
// CONFIGURATION
//  PS2_TX_ACK_CHECK_EN
//    defined: the ACK sample is checked. A 1 (NACK) ends the frame with err=1
//      instead of done=1.
//    undefined: the ack bit is not checked. The frame always ends with done=1
//      unless a timeout occurs.
// TESTING
//  1. wen, wdata=0xED; device model clocks 11 bits, acks low -> ps2_clk_oe high for
//     exactly 5000 cycles. Device samples 0,1,0,1,1,0,1,1,1,P=1,stop=1. done pulses once.
//  2. wdata=0x01 -> parity bit 0. wdata=0xFF -> parity 1. wdata=0x00 -> parity 1.
//     In each case, line bits match LSB-first order.
//  3. wen with 0x55 pulsed again mid-frame -> ignored; device still receives the first
//     byte; exactly one done.
//  4. Device never clocks -> err pulses 1000000 cycles after clock release. Both oe=0,
//     busy=0. A new wen is accepted.
//  5. Device holds data high on the ack clock -> with PS2_TX_ACK_CHECK_EN: err=1, done=0;
//     without the macro: done=1.
//  6. rst asserted after fall 5 -> next cycle: both oe=0, busy=0. No done/err.
//     A following 0xF4 transfers cleanly.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, bit shifting, ack and timeout.
// Optional macro PS2_TX_ACK_CHECK_EN: a high ack bit (NACK) ends the frame with err instead of done.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned FILTER_CYCLES  = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic       wen,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       err
);
    localparam int unsigned CMAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam int unsigned FW   = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_f, data_f, clk_f_d;
    logic [FW-1:0] clk_fcnt, data_fcnt;
    logic          fall;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_cnt_q;
    logic [8:0]    shreg_q;
    logic          data_oe_q;
    logic          last_fall;
    logic          timeout;

    // Filtered value follows the synchronized line only after FILTER_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_f     <= 1'b1;
            data_f    <= 1'b1;
            clk_f_d   <= 1'b1;
            clk_fcnt  <= '0;
            data_fcnt <= '0;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_f_d   <= clk_f;
            if (clk_sync[1] == clk_f) begin
                clk_fcnt <= '0;
            end else if (clk_fcnt == FW'(FILTER_CYCLES - 1)) begin
                clk_f    <= clk_sync[1];
                clk_fcnt <= '0;
            end else begin
                clk_fcnt <= clk_fcnt + 1'b1;
            end
            if (data_sync[1] == data_f) begin
                data_fcnt <= '0;
            end else if (data_fcnt == FW'(FILTER_CYCLES - 1)) begin
                data_f    <= data_sync[1];
                data_fcnt <= '0;
            end else begin
                data_fcnt <= data_fcnt + 1'b1;
            end
        end
    end

    assign fall      = clk_f_d & ~clk_f;
    assign last_fall = fall && (bit_cnt_q == 4'd10);
    assign timeout   = (cnt_q == CW'(TIMEOUT_CYCLES));

`ifdef PS2_TX_ACK_CHECK_EN
    logic nack_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            nack_q <= 1'b0;
        end else if (state_q == S_SHIFT && last_fall) begin
            nack_q <= data_f;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wen) state_d = S_INHIBIT;
            end
            S_INHIBIT: begin
                ps2_clk_oe = 1'b1;
                busy       = 1'b1;
                if (cnt_q == CW'(INHIBIT_CYCLES - 1)) state_d = S_REQ;
            end
            S_REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                busy        = 1'b1;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                ps2_data_oe = data_oe_q;
                busy        = 1'b1;
                // A final edge arriving on the timeout cycle still completes the frame.
                if (last_fall) begin
                    state_d = S_ACK;
                end else if (timeout) begin
                    busy    = 1'b0;
                    err     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                busy    = 1'b1;
                state_d = S_WAITIDLE;
            end
            S_WAITIDLE: begin
                busy = 1'b1;
                if (clk_f && data_f) begin
                    busy    = 1'b0;
                    state_d = S_IDLE;
`ifdef PS2_TX_ACK_CHECK_EN
                    done = ~nack_q;
                    err  = nack_q;
`else
                    done = 1'b1;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // shreg holds {parity, data}; shifting in ones makes the tenth edge present the stop bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            data_oe_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    data_oe_q <= 1'b0;
                    if (wen) shreg_q <= {~^wdata, wdata};
                end
                S_INHIBIT: cnt_q <= cnt_q + 1'b1;
                S_REQ: begin
                    cnt_q     <= '0;
                    bit_cnt_q <= '0;
                    data_oe_q <= 1'b1;
                end
                S_SHIFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (fall) begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        data_oe_q <= ~shreg_q[0];
                        shreg_q   <= {1'b1, shreg_q[8:1]};
                    end
                end
                default: data_oe_q <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and checks them
// against frames built from the byte value; covers inhibit length, parity, ignored writes, timeout, NACK and reset.
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TO   = 3000;
    localparam int FILT = 3;
    localparam int H    = 12;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk, ps2_data;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       wen;
    logic [7:0] wdata;
    logic       busy, done, err;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    assign ps2_clk  = dev_clk & ~ps2_clk_oe;
    assign ps2_data = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .FILTER_CYCLES (FILT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .wen        (wen),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line-level frame the device should see: start, 8 data bits LSB first, odd parity, stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        f[0]    = 1'b0;
        f[8:1]  = b;
        f[9]    = ((ones % 2) == 0);
        f[10]   = 1'b1;
        return f;
    endfunction

    task automatic device(input int nclk, input bit ack_low, output logic [10:0] seen,
                          output int inh, output int req, output bit ok);
        seen = '0;
        inh  = 0;
        req  = 0;
        ok   = 1'b0;
        for (int n = 0; n < INH + 200; n++) begin
            if (!ps2_clk_oe && ps2_data_oe) begin
                ok = 1'b1;
                break;
            end
            if (ps2_clk_oe && !ps2_data_oe) inh++;
            if (ps2_clk_oe && ps2_data_oe) req++;
            tick;
        end
        if (!ok) return;
        repeat (5) tick;
        seen[0] = ps2_data;
        for (int k = 1; k <= nclk; k++) begin
            dev_clk = 1'b0;
            repeat (H) tick;
            if (k <= 10) seen[k] = ps2_data;
            dev_clk = 1'b1;
            if (k == 10 && ack_low) dev_data = 1'b0;
            repeat (H) tick;
        end
        dev_data = 1'b1;
    endtask

    task automatic wait_end(input int d0, input int e0);
        for (int n = 0; n < 300; n++) begin
            if (done_cnt != d0 || err_cnt != e0) break;
            tick;
        end
        repeat (3) tick;
    endtask

    task automatic send(input logic [7:0] b, input bit ack_low, input bit extra_wen,
                        input string tag, output logic [10:0] seen);
        int  inh, req, d0, e0;
        bit  ok;
        bit  exp_err;
        exp_err = 1'b0;
`ifdef PS2_TX_ACK_CHECK_EN
        exp_err = !ack_low;
`endif
        d0 = done_cnt;
        e0 = err_cnt;
        wdata = b;
        wen   = 1'b1;
        tick;
        wen   = 1'b0;
        wdata = 8'($urandom);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        fork
            device(11, ack_low, seen, inh, req, ok);
            begin
                if (extra_wen) begin
                    repeat (INH + 60) tick;
                    wdata = 8'h55;
                    wen   = 1'b1;
                    tick;
                    wen   = 1'b0;
                end
            end
        join
        chk({tag, "_req_seen"}, 32'(ok), 32'd1);
        chk({tag, "_inhibit_len"}, 32'(inh), 32'(INH));
        chk({tag, "_req_len"}, 32'(req), 32'd1);
        chk({tag, "_frame"}, 32'(seen), 32'(model_frame(b)));
        wait_end(d0, e0);
        chk({tag, "_done"}, 32'(done_cnt - d0), exp_err ? 32'd0 : 32'd1);
        chk({tag, "_err"}, 32'(err_cnt - e0), exp_err ? 32'd1 : 32'd0);
        chk({tag, "_idle"}, {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        logic [10:0] seen;
        logic [7:0]  rb;
        int          inh, req, d0, e0, n;
        bit          ok;

        rst   = 1'b1;
        wen   = 1'b0;
        wdata = '0;
        repeat (5) tick;
        chk("reset_outputs", {27'd0, ps2_clk_oe, ps2_data_oe, busy, done, err}, 32'd0);
        rst = 1'b0;
        repeat (10) tick;

        send(8'hED, 1'b1, 1'b0, "ed", seen);
        send(8'h01, 1'b1, 1'b0, "x01", seen);
        chk("x01_parity", 32'(seen[9]), 32'd0);
        send(8'hFF, 1'b1, 1'b0, "xff", seen);
        chk("xff_parity", 32'(seen[9]), 32'd1);
        send(8'h00, 1'b1, 1'b0, "x00", seen);
        chk("x00_parity", 32'(seen[9]), 32'd1);

        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom);
            send(rb, 1'b1, 1'b0, "rand", seen);
        end

        send(8'hA3, 1'b1, 1'b1, "ignored_wen", seen);

        // Device never clocks: err expected exactly TO cycles after clock release.
        d0 = done_cnt;
        e0 = err_cnt;
        wdata = 8'h12;
        wen   = 1'b1;
        tick;
        wen   = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < INH + 50; k++) begin
            if (!ps2_clk_oe) begin
                ok = 1'b1;
                break;
            end
            tick;
        end
        chk("to_release", 32'(ok), 32'd1);
        n = 0;
        while (!err && n < TO + 50) begin
            tick;
            n++;
        end
        chk("to_latency", 32'(n), 32'(TO));
        chk("to_busy", 32'(busy), 32'd0);
        tick;
        chk("to_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("to_counts", 32'(done_cnt - d0) * 16 + 32'(err_cnt - e0), 32'd1);
        send(8'h5A, 1'b1, 1'b0, "after_to", seen);

        send(8'h3C, 1'b0, 1'b0, "nack", seen);

        // Reset mid-frame after the fifth device clock edge.
        d0 = done_cnt;
        e0 = err_cnt;
        wdata = 8'hC6;
        wen   = 1'b1;
        tick;
        wen   = 1'b0;
        device(5, 1'b1, seen, inh, req, ok);
        chk("rst_mid_started", 32'(ok), 32'd1);
        rst = 1'b1;
        tick;
        chk("rst_mid_lines", {29'd0, busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        repeat (50) tick;
        chk("rst_mid_no_pulse", 32'(done_cnt - d0) * 16 + 32'(err_cnt - e0), 32'd0);
        send(8'hF4, 1'b1, 1'b0, "after_rst", seen);

        chk("done_err_exclusive", 32'(both_cnt), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
